// File: rtl/alu_interface_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : alu_interface_pkg
//  Purpose  : Shared state encoding and ALU opcode constants for alu_interface.
//  Revision : 1.0 - initial release
// ============================================================================
package alu_interface_pkg;

    localparam logic [2:0] c_st_wait_a  = 3'd0;
    localparam logic [2:0] c_st_wait_b  = 3'd1;
    localparam logic [2:0] c_st_wait_op = 3'd2;
    localparam logic [2:0] c_st_send    = 3'd3;
    localparam logic [2:0] c_st_wait_tx = 3'd4;

    localparam logic [5:0] c_op_add = 6'h20;
    localparam logic [5:0] c_op_sub = 6'h22;
    localparam logic [5:0] c_op_and = 6'h24;
    localparam logic [5:0] c_op_or  = 6'h25;
    localparam logic [5:0] c_op_xor = 6'h26;
    localparam logic [5:0] c_op_nor = 6'h27;
    localparam logic [5:0] c_op_sra = 6'h03;
    localparam logic [5:0] c_op_srl = 6'h02;

    function automatic logic is_busy_state(input logic [2:0] st);
        return (st == c_st_send) || (st == c_st_wait_tx);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_if_timer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : alu_if_timer
//  Purpose  : Idle-cycle counter; flags expiry after TIMEOUT enabled cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_if_timer #(
    parameter int TIMEOUT = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int c_w = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [c_w-1:0] r_count;

    assign expired = (r_count == c_w'(TIMEOUT - 1));

    // Counter saturates at expiry; the FSM leaves the waiting state and clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en && !expired) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_interface.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : alu_interface
//  Purpose  : Collects operand A, operand B and opcode bytes from a UART
//             receiver, drives an external ALU and sends back its result.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_interface #(
    parameter int N       = 8,
    parameter int TIMEOUT = 100000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rx_done,
    input  logic [7:0]   rx_data,
    input  logic         tx_done,
    output logic         tx_start,
    output logic [7:0]   tx_data,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [5:0]   alu_op,
    input  logic [N-1:0] alu_result,
    output logic         busy
);

    import alu_interface_pkg::*;

    logic [2:0]   r_state;
    logic [2:0]   w_state_next;
    logic [N-1:0] r_alu_a;
    logic [N-1:0] r_alu_b;
    logic [5:0]   r_alu_op;
    logic [7:0]   r_tx_data;
    logic         r_tx_start;
    logic [7:0]   w_result_ext;
    logic         w_timer_clr;
    logic         w_timer_en;
    logic         w_expired;

    // A byte arriving on the expiry cycle wins over the timeout.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_wait_a: begin
                if (rx_done) w_state_next = c_st_wait_b;
            end
            c_st_wait_b: begin
                if (rx_done)        w_state_next = c_st_wait_op;
                else if (w_expired) w_state_next = c_st_wait_a;
            end
            c_st_wait_op: begin
                if (rx_done)        w_state_next = c_st_send;
                else if (w_expired) w_state_next = c_st_wait_a;
            end
            c_st_send: begin
                w_state_next = c_st_wait_tx;
            end
            c_st_wait_tx: begin
                if (tx_done) w_state_next = c_st_wait_a;
            end
            default: begin
                w_state_next = c_st_wait_a;
            end
        endcase
    end

    always_comb begin
        w_result_ext         = '0;
        w_result_ext[N-1:0]  = alu_result;
    end

    // Every accepted byte also changes state, so a state change covers both clears.
    assign w_timer_clr = (w_state_next != r_state);
    assign w_timer_en  = (r_state == c_st_wait_b) || (r_state == c_st_wait_op);

    alu_if_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (w_timer_clr),
        .en      (w_timer_en),
        .expired (w_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_st_wait_a;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_op   <= '0;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_tx_start <= 1'b0;
            if (rx_done && (r_state == c_st_wait_a))  r_alu_a  <= rx_data[N-1:0];
            if (rx_done && (r_state == c_st_wait_b))  r_alu_b  <= rx_data[N-1:0];
            if (rx_done && (r_state == c_st_wait_op)) r_alu_op <= rx_data[5:0];
            if (r_state == c_st_send) begin
                r_tx_data  <= w_result_ext;
                r_tx_start <= 1'b1;
            end
        end
    end

    assign alu_a    = r_alu_a;
    assign alu_b    = r_alu_b;
    assign alu_op   = r_alu_op;
    assign tx_data  = r_tx_data;
    assign tx_start = r_tx_start;
    assign busy     = is_busy_state(r_state);

endmodule
`default_nettype wire

// File: tb/tb_alu_interface.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_alu_interface
//  Purpose  : Scoreboard bench driving an N=8 and an N=7 instance in lockstep.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_interface;
    import alu_interface_pkg::*;

    localparam int TMO = 16;

    logic       clk     = 1'b0;
    logic       reset   = 1'b0;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_done = 1'b0;

    logic       tx_start8, busy8, tx_start7, busy7;
    logic [7:0] tx_data8, tx_data7;
    logic [7:0] a8, b8, res8;
    logic [6:0] a7, b7, res7;
    logic [5:0] op8, op7;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU: signed A, single-bit shifts, undefined opcodes give 0.
    function automatic logic [7:0] ref_alu(input int n, input logic [7:0] a,
                                           input logic [7:0] b, input logic [5:0] op);
        int mask, ai, bi, sa, r;
        mask = (1 << n) - 1;
        ai   = int'(a) & mask;
        bi   = int'(b) & mask;
        sa   = (ai >= (1 << (n - 1))) ? ai - (1 << n) : ai;
        case (op)
            c_op_add: r = ai + bi;
            c_op_sub: r = ai - bi;
            c_op_and: r = ai & bi;
            c_op_or:  r = ai | bi;
            c_op_xor: r = ai ^ bi;
            c_op_nor: r = ~(ai | bi);
            c_op_sra: r = sa >>> 1;
            c_op_srl: r = ai >> 1;
            default:  r = 0;
        endcase
        return 8'(r & mask);
    endfunction

    assign res8 = ref_alu(8, a8, b8, op8);
    assign res7 = 7'(ref_alu(7, {1'b0, a7}, {1'b0, b7}, op7));

    alu_interface #(.N(8), .TIMEOUT(TMO)) dut8 (
        .clk(clk), .reset(reset), .rx_done(rx_done), .rx_data(rx_data),
        .tx_done(tx_done), .tx_start(tx_start8), .tx_data(tx_data8),
        .alu_a(a8), .alu_b(b8), .alu_op(op8), .alu_result(res8), .busy(busy8)
    );

    alu_interface #(.N(7), .TIMEOUT(TMO)) dut7 (
        .clk(clk), .reset(reset), .rx_done(rx_done), .rx_data(rx_data),
        .tx_done(tx_done), .tx_start(tx_start7), .tx_data(tx_data7),
        .alu_a(a7), .alu_b(b7), .alu_op(op7), .alu_result(res7), .busy(busy7)
    );

    typedef struct {
        int         cyc;
        logic [7:0] a8;
        logic [7:0] b8;
        logic [5:0] op;
        logic [7:0] d8;
        logic [6:0] a7;
        logic [7:0] d7;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] pend[$];
    int         last_k    = 0;
    bit         in_flight = 1'b0;
    logic [7:0] ma8 = '0, mb8 = '0;
    logic [6:0] ma7 = '0, mb7 = '0;
    logic [5:0] mop = '0;
    logic [5:0] ops[8] = '{c_op_add, c_op_sub, c_op_and, c_op_or,
                           c_op_xor, c_op_nor, c_op_sra, c_op_srl};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every tx_start must match the oldest outstanding transaction.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && (tx_start8 || tx_start7)) begin
            if (sb.size() == 0) begin
                check("unexpected_tx_start", {30'd0, tx_start8, tx_start7}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("tx_start_both", {30'd0, tx_start8, tx_start7}, 32'd3);
                check("tx_start_cycle", cyc, e.cyc);
                check("tx_data_n8", tx_data8, e.d8);
                check("tx_data_n7", tx_data7, e.d7);
                check("alu_a_n8", a8, e.a8);
                check("alu_b_n8", b8, e.b8);
                check("alu_op", op8, e.op);
                check("alu_a_n7", a7, e.a7);
            end
        end
    end

    // Called at posedge+1: the byte is sampled on the next rising edge.
    task automatic send_byte(input logic [7:0] b);
        exp_t e;
        int   k;
        k = cyc;
        if (!in_flight) begin
            if (pend.size() > 0 && (k - last_k - 1) >= TMO) pend.delete();
            pend.push_back(b);
            last_k = k;
            if (pend.size() == 1) begin
                ma8 = b; ma7 = b[6:0];
            end else if (pend.size() == 2) begin
                mb8 = b; mb7 = b[6:0];
            end else begin
                mop  = b[5:0];
                e.cyc = k + 2;
                e.a8  = pend[0];
                e.b8  = pend[1];
                e.op  = b[5:0];
                e.a7  = pend[0][6:0];
                e.d8  = ref_alu(8, pend[0], pend[1], b[5:0]);
                e.d7  = ref_alu(7, pend[0], pend[1], b[5:0]);
                sb.push_back(e);
                in_flight = 1'b1;
                pend.delete();
            end
        end
        rx_done = 1'b1;
        rx_data = b;
        @(posedge clk); #1;
        rx_done = 1'b0;
        rx_data = 8'($urandom);
        check("busy", {30'd0, busy8, busy7}, in_flight ? 32'd3 : 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            if (!in_flight && $urandom_range(0, 7) == 0) tx_done = 1'b1;
            @(posedge clk); #1;
            tx_done = 1'b0;
        end
    endtask

    task automatic check_regs();
        check("regs_n8", {10'd0, a8, b8, op8}, {10'd0, ma8, mb8, mop});
        check("regs_n7", {12'd0, a7, b7, op7}, {12'd0, ma7, mb7, mop});
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        reset = 1'b1;
        #1;
        check("reset_outputs_n8", {tx_start8, tx_data8, a8, b8, op8, busy8}, 32'd0);
        check("reset_outputs_n7", {2'd0, tx_start7, tx_data7, a7, b7, op7, busy7}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        pend.delete();
        in_flight = 1'b0;
        ma8 = '0; mb8 = '0; ma7 = '0; mb7 = '0; mop = '0;
    endtask

    // mode 0: plain tx_done, 1: stray byte first, 2: reset instead of tx_done
    task automatic tx_phase(input int mode);
        int n;
        n = 0;
        while (!tx_start8 && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 8) check("tx_start_timeout", 32'd0, 32'd1);
        check("busy_during_tx", {30'd0, busy8, busy7}, 32'd3);
        idle($urandom_range(0, 3));
        if (mode == 1) begin
            send_byte(8'h77);
            idle($urandom_range(0, 2));
        end
        if (mode == 2) begin
            do_reset();
        end else begin
            tx_done = 1'b1;
            @(posedge clk); #1;
            tx_done = 1'b0;
            in_flight = 1'b0;
            check("busy_after_tx_done", {30'd0, busy8, busy7}, 32'd0);
        end
    endtask

    task automatic txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                       input int mode);
        send_byte(a);
        send_byte(b);
        send_byte(op);
        tx_phase(mode);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        do_reset();
        check_regs();

        txn(8'h05, 8'h03, 8'h20, 0);
        check("known_add", {tx_data8, a8, b8}, {8'h08, 8'h05, 8'h03});
        txn(8'h03, 8'h05, 8'h22, 0);
        check("known_sub", tx_data8, 8'hFE);
        txn(8'h80, 8'h00, 8'h03, 0);
        check("known_sra", tx_data8, 8'hC0);
        txn(8'hFF, 8'h01, 8'h20, 0);
        check("known_n7_add", {tx_data7, 1'b0, a7}, {8'h00, 8'h7F});
        txn(8'h12, 8'h34, 8'h3F, 0);
        check("known_undef_op", {tx_data8, tx_data7}, 16'h0000);

        send_byte(8'h05);
        idle(TMO);
        check_regs();
        txn(8'h09, 8'h01, 8'h20, 0);
        check("known_timeout_new_a", tx_data8, 8'h0A);
        send_byte(8'h07);
        idle(TMO - 1);
        txn(8'h02, 8'h20, 8'h00, 0);
        check("known_last_cycle_accept", {a8, b8}, {8'h07, 8'h02});

        txn(8'h05, 8'h05, 8'h20, 1);
        txn(8'h01, 8'h01, 8'h20, 0);
        check("known_after_stray", tx_data8, 8'h02);

        send_byte(8'h11);
        send_byte(8'h22);
        do_reset();
        check_regs();
        txn(8'h04, 8'h02, 8'h22, 0);
        check("known_after_reset", tx_data8, 8'h02);
        txn(8'h01, 8'h02, 8'h20, 2);
        check_regs();

        for (int it = 0; it < 300; it++) begin
            int r;
            r = $urandom_range(0, 99);
            idle((r < 10) ? $urandom_range(TMO - 2, TMO + 2) : $urandom_range(0, 3));
            b = 8'($urandom);
            if (pend.size() == 2 && (r % 3) != 0) b[5:0] = ops[$urandom_range(0, 7)];
            send_byte(b);
            if (in_flight) begin
                tx_phase((r < 4) ? 2 : (r % 2));
            end else if (r >= 96) begin
                do_reset();
            end
            check_regs();
        end

        @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
